// File: rtl/fsm_pkg.sv
// Shared encodings for the 101 serial link: transmitter states and the sync marker.
// Also holds a small helper for sizing the transmitter's shared bit counter.
package fsm_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SYNC_A = 3'd1,
        SYNC_B = 3'd2,
        SYNC_C = 3'd3,
        DATA   = 3'd4,
        GUARD  = 3'd5
    } state_t;

    // Emitted MSB first by SYNC_A, SYNC_B and SYNC_C.
    localparam logic [2:0] SYNC_MARKER = 3'b101;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync101_serial_tx_piso.sv
// Parallel-in serial-out shift register: parallel load, shift-left enable, MSB out.
// Load takes priority over shift; asynchronous active-high reset clears it to 0.
module piso_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] d_in,
    output logic             msb_out
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (load) begin
            shreg_d = d_in;
        end else if (shift_en) begin
            shreg_d = shreg_q << 1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign msb_out = shreg_q[WIDTH-1];

endmodule

// File: rtl/sync101_serial_tx.sv
// Frame transmitter for the 101 detectors: sync marker 1-0-1, payload MSB first, guard zeros.
// Accepts words over valid/ready and chains frames back to back when a word is waiting.
module sync101_serial_tx
    import fsm_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int GUARD_BITS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             tx_bit,
    output logic             busy,
    output logic             frame_done
);

    localparam int CNT_W = $clog2(max_int(WIDTH, GUARD_BITS)) + 1;
    localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic handshake;
    logic last_guard;
    logic shift_en;
    logic shift_msb;

    piso_shift_reg #(
        .WIDTH (WIDTH)
    ) u_piso (
        .clk      (clk),
        .reset    (reset),
        .load     (handshake),
        .shift_en (shift_en),
        .d_in     (data_in),
        .msb_out  (shift_msb)
    );

    // Ready in IDLE or on the final guard bit, so a waiting word chains with no gap.
    assign last_guard = (state_q == GUARD) && (cnt_q == GUARD_LAST);
    assign data_ready = (state_q == IDLE) || last_guard;
    assign handshake  = data_valid && data_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    state_d = SYNC_A;
                    cnt_d   = '0;
                end
            end
            SYNC_A: begin
                state_d = SYNC_B;
                cnt_d   = '0;
            end
            SYNC_B: begin
                state_d = SYNC_C;
                cnt_d   = '0;
            end
            SYNC_C: begin
                state_d = DATA;
                cnt_d   = '0;
            end
            DATA: begin
                shift_en = 1'b1;
                if (cnt_q == DATA_LAST) begin
                    state_d = GUARD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            GUARD: begin
                if (last_guard) begin
                    state_d = handshake ? SYNC_A : IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Line outputs come from registered state only; the idle and guard line is 0.
    always_comb begin
        tx_bit = 1'b0;
        case (state_q)
            SYNC_A:  tx_bit = SYNC_MARKER[2];
            SYNC_B:  tx_bit = SYNC_MARKER[1];
            SYNC_C:  tx_bit = SYNC_MARKER[0];
            DATA:    tx_bit = shift_msb;
            default: tx_bit = 1'b0;
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign frame_done = last_guard;

endmodule

// File: tb/tb_sync101_serial_tx.sv
// Bench for sync101_serial_tx: table of single frames, directed chaining/abort/WIDTH=1 cases,
// and random traffic compared every cycle against a queue-of-bits stream model.
module tb_sync101_serial_tx;

    localparam int W = 8;
    localparam int G = 1;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         data_valid = 1'b0;
    logic         data_ready, tx_bit, busy, frame_done;

    logic [0:0]   data_in1 = '0;
    logic         data_valid1 = 1'b0;
    logic         data_ready1, tx_bit1, busy1, frame_done1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sync101_serial_tx #(.WIDTH(W), .GUARD_BITS(G)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .tx_bit     (tx_bit),
        .busy       (busy),
        .frame_done (frame_done)
    );

    sync101_serial_tx #(.WIDTH(1), .GUARD_BITS(3)) u_dut1 (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in1),
        .data_valid (data_valid1),
        .data_ready (data_ready1),
        .tx_bit     (tx_bit1),
        .busy       (busy1),
        .frame_done (frame_done1)
    );

    // Stream model: the line is simply the queue of bits still to be sent.
    typedef struct {
        logic b;
        logic last;
    } mbit_t;

    mbit_t q[$];
    logic  accepted = 1'b0;

    task automatic push_frame(input logic [W-1:0] w);
        mbit_t m;
        logic [2:0] marker;
        marker = 3'b101;
        for (int i = 2; i >= 0; i--) begin
            m.b = marker[i]; m.last = 1'b0; q.push_back(m);
        end
        for (int i = W - 1; i >= 0; i--) begin
            m.b = w[i]; m.last = 1'b0; q.push_back(m);
        end
        for (int g = 0; g < G; g++) begin
            m.b = 1'b0; m.last = (g == G - 1); q.push_back(m);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            accepted = 1'b0;
        end else begin : model_step
            logic rdy;
            rdy = (q.size() <= 1);
            if (q.size() > 0) q.delete(0);
            accepted = data_valid && rdy;
            if (accepted) push_frame(data_in);
        end
    end

    always @(negedge clk) begin : model_cmp
        logic m_tx, m_busy, m_done, m_ready;
        #1;
        m_busy  = (q.size() != 0);
        m_tx    = m_busy ? q[0].b : 1'b0;
        m_done  = m_busy ? q[0].last : 1'b0;
        m_ready = (q.size() <= 1);
        tests++;
        if ({tx_bit, busy, frame_done, data_ready} !== {m_tx, m_busy, m_done, m_ready}) begin
            fails++;
            $display("[TB] FAIL model_cmp t=%0t got tx/busy/done/ready=%b%b%b%b expected %b%b%b%b",
                     $time, tx_bit, busy, frame_done, data_ready, m_tx, m_busy, m_done, m_ready);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  word;
        bit          pulse;
        logic [11:0] stream;
    } vec_t;

    vec_t vecs[5];

    // One frame from IDLE: 12 line cycles checked as whole vectors, then the idle line.
    task automatic run_frame(input vec_t v);
        logic [11:0] got_tx, got_done, got_busy;
        @(negedge clk);
        data_in = v.word;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            got_tx[11-i]   = tx_bit;
            got_done[11-i] = frame_done;
            got_busy[11-i] = busy;
            if (v.pulse && i == 5) begin
                check("ready_low_in_data", {31'd0, data_ready}, 32'd0);
                data_valid = 1'b1;
                data_in = ~v.word;
            end else begin
                data_valid = 1'b0;
            end
            @(negedge clk);
        end
        check($sformatf("stream_%h", v.word), {20'd0, got_tx}, {20'd0, v.stream});
        check($sformatf("done_%h", v.word), {20'd0, got_done}, 32'h001);
        check($sformatf("busy_%h", v.word), {20'd0, got_busy}, 32'hFFF);
        check("idle_after_frame", {30'd0, tx_bit, busy}, 32'd0);
    endtask

    task automatic applyStimulus();
        vec_t v;
        logic [23:0] got24_tx, got24_busy, got24_done;
        logic [13:0] got14_tx, got14_done;
        int wait_cnt;

        vecs[0] = '{word: 8'hA5, pulse: 1'b0, stream: 12'hB4A};
        vecs[1] = '{word: 8'hFF, pulse: 1'b0, stream: 12'hBFE};
        vecs[2] = '{word: 8'h00, pulse: 1'b0, stream: 12'hA00};
        vecs[3] = '{word: 8'hC3, pulse: 1'b1, stream: 12'hB86};
        vecs[4] = '{word: 8'h5A, pulse: 1'b1, stream: 12'hAB4};

        // Reset with a handshake attempt held throughout.
        #2 reset = 1'b1;
        data_valid = 1'b1;
        data_in = 8'hA5;
        data_valid1 = 1'b1;
        data_in1 = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", {28'd0, tx_bit, busy, frame_done, data_ready}, 32'h1);
        check("reset_outputs_w1", {28'd0, tx_bit1, busy1, frame_done1, data_ready1}, 32'h1);
        data_valid = 1'b0;
        data_valid1 = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("idle_after_reset", {31'd0, busy}, 32'd0);

        for (int k = 0; k < 5; k++) run_frame(vecs[k]);

        // Back-to-back 8'hFF then 8'h00 with valid held.
        @(negedge clk);
        data_in = 8'hFF;
        data_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 24; i++) begin
            got24_tx[23-i]   = tx_bit;
            got24_busy[23-i] = busy;
            got24_done[23-i] = frame_done;
            if (i == 0) data_in = 8'h00;
            if (i == 12) data_valid = 1'b0;
            @(negedge clk);
        end
        check("b2b_stream", {8'd0, got24_tx}, 32'hBFEA00);
        check("b2b_busy", {8'd0, got24_busy}, 32'hFFFFFF);
        check("b2b_done", {8'd0, got24_done}, 32'h001001);
        check("b2b_idle_after", {30'd0, tx_bit, busy}, 32'd0);

        // Reset at cycle N+6 of an 8'hC3 frame, then a clean frame.
        @(negedge clk);
        data_in = 8'hC3;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_outputs", {28'd0, tx_bit, busy, frame_done, data_ready}, 32'h1);
        @(negedge clk);
        reset = 1'b0;
        v = '{word: 8'hA5, pulse: 1'b0, stream: 12'hB4A};
        run_frame(v);

        // WIDTH=1, GUARD_BITS=3: two chained frames of a 1, period 7.
        @(negedge clk);
        data_in1 = 1'b1;
        data_valid1 = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            got14_tx[13-i]   = tx_bit1;
            got14_done[13-i] = frame_done1;
            if (i == 7) data_valid1 = 1'b0;
            @(negedge clk);
        end
        check("w1_stream", {18'd0, got14_tx}, {18'd0, 14'b1011000_1011000});
        check("w1_done", {18'd0, got14_done}, {18'd0, 14'b0000001_0000001});
        check("w1_idle_after", {30'd0, tx_bit1, busy1}, 32'd0);

        // Random traffic; data held until accepted.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (!data_valid || accepted) begin
                data_valid = ($urandom_range(0, 3) != 0);
                data_in = W'($urandom);
            end
        end
        @(negedge clk);
        data_valid = 1'b0;
        wait_cnt = 0;
        while (busy && wait_cnt < 50) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("random_drain_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic checkOutput();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
    endtask

    initial begin
        applyStimulus();
        @(negedge clk);
        checkOutput();
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "[TB] watchdog");
    end

endmodule
